ag32gbd_quant: RTL and testbench

Quantiser stage between the sensor capture FSM and the block-RAM controller. It takes the 8-bit ADC sample stream for a 128x112 Game Boy Camera frame and compares each sample against the per-position thresholds of the 4x4 compare matrix, which holds three bytes per cell. It packs the resulting 2-bit pixels four to a byte and writes them into the active 8-row image buffer. After each completed 8-row block it pulses `FlipBuffer` and `BlockDone` so that `ag32gbd_ram_write` can drain the finished buffer.

---
 rtl/ag32gbd_quant.sv | 162 ++++++++++++++++
 tb/tb_ag32gbd_quant.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ag32gbd_quant.sv
// Quantiser: compares camera samples against a 4x4 threshold matrix held
// in BRAM and packs 2-bit pixels four to a byte into the active image buffer.
module ag32gbd_quant #(
  parameter logic [9:0] MAT_BASE = 10'h200,
  parameter int         ROWS     = 112
) (
  input  logic       sys_clock,
  input  logic       sys_reset,
  input  logic       Frame_Start,
  input  logic       Pix_Valid,
  input  logic [7:0] Pix_Data,
  output logic       Pix_Ready,
  output logic       RequestReadReg,
  output logic [9:0] RegReadAddr,
  input  logic [7:0] RegReadOutput,
  input  logic       RegReadDataReady,
  output logic       RequestWriteBuffer,
  output logic [9:0] BufferWriteOffset,
  output logic [7:0] BufferWriteData,
  input  logic       BufferWriteDataDone,
  output logic       FlipBuffer,
  output logic       BlockDone,
  output logic       FrameDone
);

  localparam int YW = $clog2(ROWS + 1);
  localparam logic [YW-1:0] YLAST = YW'(ROWS - 1);
  localparam logic [YW-1:0] YEND  = YW'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_L, S_RD_M, S_RD_H, S_CMP, S_WR, S_FLIP
  } state_e;

  state_e          state_q;
  logic [6:0]      x_q;
  logic [YW-1:0]   y_q;
  logic [7:0]      samp_q, l_q, m_q, h_q, sh_q;
  logic            rdy_q, rreq_q, wreq_q, flip_q, fdone_q;
  logic [9:0]      raddr_q, woff_q;
  logic [7:0]      wdata_q;

  logic [1:0]      code_d;
  logic [7:0]      pack_d;
  logic [9:0]      lbase_d;
  logic [6:0]      x_d;

  // First matching rule wins, so non-monotonic thresholds still resolve.
  always_comb begin
    code_d = 2'b11;
    if (samp_q >= h_q)      code_d = 2'b00;
    else if (samp_q >= m_q) code_d = 2'b01;
    else if (samp_q >= l_q) code_d = 2'b10;
  end

  assign pack_d  = {sh_q[5:0], code_d};
  assign lbase_d = MAT_BASE + 10'(y_q[1:0]) * 10'd12
                 + 10'(x_q[1:0]) * 10'd3;
  assign x_d     = x_q + 7'd1;

  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      samp_q  <= '0;
      l_q     <= '0;
      m_q     <= '0;
      h_q     <= '0;
      sh_q    <= '0;
      rdy_q   <= 1'b0;
      rreq_q  <= 1'b0;
      wreq_q  <= 1'b0;
      flip_q  <= 1'b0;
      fdone_q <= 1'b0;
      raddr_q <= '0;
      woff_q  <= '0;
      wdata_q <= '0;
    end else begin
      rdy_q   <= 1'b0;
      flip_q  <= 1'b0;
      fdone_q <= 1'b0;
      if (Frame_Start) begin
        state_q <= S_IDLE;
        x_q     <= '0;
        y_q     <= '0;
        samp_q  <= '0;
        l_q     <= '0;
        m_q     <= '0;
        h_q     <= '0;
        sh_q    <= '0;
        rreq_q  <= 1'b0;
        wreq_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: if (Pix_Valid) begin
            samp_q  <= Pix_Data;
            rdy_q   <= 1'b1;
            rreq_q  <= 1'b1;
            raddr_q <= lbase_d;
            state_q <= S_RD_L;
          end
          S_RD_L: if (RegReadDataReady) begin
            l_q     <= RegReadOutput;
            raddr_q <= raddr_q + 10'd1;
            state_q <= S_RD_M;
          end
          S_RD_M: if (RegReadDataReady) begin
            m_q     <= RegReadOutput;
            raddr_q <= raddr_q + 10'd1;
            state_q <= S_RD_H;
          end
          S_RD_H: if (RegReadDataReady) begin
            h_q     <= RegReadOutput;
            rreq_q  <= 1'b0;
            state_q <= S_CMP;
          end
          S_CMP: begin
            sh_q <= pack_d;
            if (x_q[1:0] == 2'd3) begin
              wreq_q  <= 1'b1;
              woff_q  <= {2'b00, y_q[2:0], x_q[6:2]};
              wdata_q <= pack_d;
              state_q <= S_WR;
            end else begin
              x_q     <= x_d;
              state_q <= S_IDLE;
            end
          end
          S_WR: if (BufferWriteDataDone) begin
            wreq_q  <= 1'b0;
            x_q     <= x_d;
            state_q <= S_IDLE;
            if (x_q == 7'd127) begin
              y_q <= y_q + 1'b1;
              if (y_q[2:0] == 3'd7) begin
                flip_q  <= 1'b1;
                fdone_q <= (y_q == YLAST);
                state_q <= S_FLIP;
              end
            end
          end
          S_FLIP: begin
            if (y_q == YEND) y_q <= '0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign Pix_Ready          = rdy_q;
  assign RequestReadReg     = rreq_q;
  assign RegReadAddr        = raddr_q;
  assign RequestWriteBuffer = wreq_q;
  assign BufferWriteOffset  = woff_q;
  assign BufferWriteData    = wdata_q;
  assign FlipBuffer         = flip_q;
  assign BlockDone          = flip_q;
  assign FrameDone          = fdone_q;

endmodule

// File: tb/tb_ag32gbd_quant.sv
// Scoreboard bench for ag32gbd_quant: directed pixels, BRAM/buffer
// responders with programmable latency, queue-based response checking.
module tb_ag32gbd_quant;
  localparam int ROWS = 16;

  logic       sys_clock = 1'b0;
  logic       sys_reset = 1'b1;
  logic       Frame_Start = 1'b0;
  logic       Pix_Valid = 1'b0;
  logic [7:0] Pix_Data = '0;
  logic       Pix_Ready;
  logic       RequestReadReg;
  logic [9:0] RegReadAddr;
  logic [7:0] RegReadOutput = '0;
  logic       RegReadDataReady = 1'b0;
  logic       RequestWriteBuffer;
  logic [9:0] BufferWriteOffset;
  logic [7:0] BufferWriteData;
  logic       BufferWriteDataDone = 1'b0;
  logic       FlipBuffer, BlockDone, FrameDone;

  always #5 sys_clock = ~sys_clock;

  ag32gbd_quant #(.MAT_BASE(10'h200), .ROWS(ROWS)) dut (
    .sys_clock(sys_clock), .sys_reset(sys_reset),
    .Frame_Start(Frame_Start), .Pix_Valid(Pix_Valid),
    .Pix_Data(Pix_Data), .Pix_Ready(Pix_Ready),
    .RequestReadReg(RequestReadReg), .RegReadAddr(RegReadAddr),
    .RegReadOutput(RegReadOutput),
    .RegReadDataReady(RegReadDataReady),
    .RequestWriteBuffer(RequestWriteBuffer),
    .BufferWriteOffset(BufferWriteOffset),
    .BufferWriteData(BufferWriteData),
    .BufferWriteDataDone(BufferWriteDataDone),
    .FlipBuffer(FlipBuffer), .BlockDone(BlockDone),
    .FrameDone(FrameDone)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  logic [7:0] mat [48];
  int dmin = 0, dmax = 0;
  int cyc = 0;
  always @(posedge sys_clock) cyc <= cyc + 1;

  function automatic logic [7:0] rd_mat(input logic [9:0] a);
    if (a >= 10'h200 && a < 10'h230) return mat[int'(a - 10'h200)];
    return 8'hEE;
  endfunction

  int rcnt = 0, rdly = 0, wcnt = 0, wdly = 0;
  always @(posedge sys_clock) begin
    if (sys_reset) begin
      RegReadDataReady <= 1'b0;
      rcnt <= 0;
    end else if (RegReadDataReady) begin
      RegReadDataReady <= 1'b0;
      rcnt <= 0;
      rdly <= int'($urandom_range(dmax, dmin));
    end else if (RequestReadReg) begin
      if (rcnt >= rdly) begin
        RegReadDataReady <= 1'b1;
        RegReadOutput <= rd_mat(RegReadAddr);
      end else rcnt <= rcnt + 1;
    end else begin
      rcnt <= 0;
      rdly <= int'($urandom_range(dmax, dmin));
    end
  end

  always @(posedge sys_clock) begin
    if (sys_reset) begin
      BufferWriteDataDone <= 1'b0;
      wcnt <= 0;
    end else if (BufferWriteDataDone) begin
      BufferWriteDataDone <= 1'b0;
      wcnt <= 0;
      wdly <= int'($urandom_range(dmax, dmin));
    end else if (RequestWriteBuffer) begin
      if (wcnt >= wdly) BufferWriteDataDone <= 1'b1;
      else wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
      wdly <= int'($urandom_range(dmax, dmin));
    end
  end

  int exp_rd [$];
  int exp_wr [$];
  bit exp_fl [$];
  int rd_log [16384];
  int wo_log [4096];
  int wd_log [4096];
  int rd_n = 0, wr_n = 0, blk_n = 0, fd_n = 0, wr_cyc = 0;
  logic p_rr = 0, p_rk = 0, p_wr = 0, p_wk = 0, p_pr = 0;
  logic [9:0] p_ra = '0, p_wo = '0;
  logic [7:0] p_wd = '0;

  always @(negedge sys_clock) begin
    if (sys_reset) begin
      p_rr = 0; p_rk = 0; p_wr = 0; p_wk = 0; p_pr = 0;
    end else begin
      if (RequestReadReg && RegReadDataReady) begin
        if (rd_n < 16384) rd_log[rd_n] = int'(RegReadAddr);
        rd_n++;
        if (exp_rd.size() == 0) fail("rd_unexpected");
        else chk("rd_addr", int'(RegReadAddr), exp_rd.pop_front());
      end
      if (RequestWriteBuffer && BufferWriteDataDone) begin
        if (wr_n < 4096) begin
          wo_log[wr_n] = int'(BufferWriteOffset);
          wd_log[wr_n] = int'(BufferWriteData);
        end
        wr_n++;
        wr_cyc = cyc;
        if (exp_wr.size() == 0) fail("wr_unexpected");
        else begin
          int e;
          e = exp_wr.pop_front();
          chk("wr_off", int'(BufferWriteOffset), e >> 8);
          chk("wr_data", int'(BufferWriteData), e & 255);
        end
      end
      if (FlipBuffer) begin
        blk_n++;
        if (FrameDone) fd_n++;
        chk("blockdone_with_flip", int'(BlockDone), 1);
        chk("flip_latency", cyc, wr_cyc + 1);
        if (exp_fl.size() == 0) fail("flip_unexpected");
        else chk("framedone", int'(FrameDone), int'(exp_fl.pop_front()));
      end else if (BlockDone || FrameDone) fail("pulse_without_flip");
      if (RequestReadReg && RequestWriteBuffer) fail("two_requests");
      if (p_pr && Pix_Ready) fail("pix_ready_back_to_back");
      if (p_rr && !p_rk && RequestReadReg)
        chk("rd_addr_stable", int'(RegReadAddr), int'(p_ra));
      if (p_wr && !p_wk && RequestWriteBuffer) begin
        chk("wr_off_stable", int'(BufferWriteOffset), int'(p_wo));
        chk("wr_data_stable", int'(BufferWriteData), int'(p_wd));
      end
      p_rr = RequestReadReg; p_rk = RegReadDataReady; p_ra = RegReadAddr;
      p_wr = RequestWriteBuffer; p_wk = BufferWriteDataDone;
      p_wo = BufferWriteOffset; p_wd = BufferWriteData;
      p_pr = Pix_Ready;
    end
  end

  int mx = 0, my = 0;
  logic [7:0] msh = '0;

  function automatic logic [1:0] quant(input logic [7:0] s, l, m, h);
    if (s >= h) return 2'b00;
    if (s >= m) return 2'b01;
    if (s >= l) return 2'b10;
    return 2'b11;
  endfunction

  task automatic model_pix(input logic [7:0] d);
    int b;
    b = 12 * (my % 4) + 3 * (mx % 4);
    for (int k = 0; k < 3; k++) exp_rd.push_back(32'h200 + b + k);
    msh = {msh[5:0], quant(d, mat[b], mat[b+1], mat[b+2])};
    if (mx % 4 == 3)
      exp_wr.push_back((((my % 8) * 32 + mx / 4) << 8) | int'(msh));
    if (mx == 127) begin
      if (my % 8 == 7) exp_fl.push_back(my == ROWS - 1);
      my = (my == ROWS - 1) ? 0 : my + 1;
    end
    mx = (mx + 1) % 128;
  endtask

  task automatic model_reset();
    mx = 0; my = 0; msh = '0;
    exp_rd.delete(); exp_wr.delete(); exp_fl.delete();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(negedge sys_clock);
      n++;
    end while (!Pix_Ready && n < 300);
    if (!Pix_Ready) fail("pix_ready_timeout");
    @(posedge sys_clock); #1;
    Pix_Valid = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] d);
    @(posedge sys_clock); #1;
    Pix_Valid = 1'b1;
    Pix_Data = d;
    model_pix(d);
    wait_ready();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_rd.size() + exp_wr.size() + exp_fl.size()) != 0
           && n < 400) begin
      @(negedge sys_clock);
      n++;
    end
    if (n >= 400) fail("drain_timeout");
    repeat (2) @(negedge sys_clock);
  endtask

  task automatic check_zero(input string t);
    chk({t, "_pix_ready"}, int'(Pix_Ready), 0);
    chk({t, "_rd_req"}, int'(RequestReadReg), 0);
    chk({t, "_rd_addr"}, int'(RegReadAddr), 0);
    chk({t, "_wr_req"}, int'(RequestWriteBuffer), 0);
    chk({t, "_wr_off"}, int'(BufferWriteOffset), 0);
    chk({t, "_wr_data"}, int'(BufferWriteData), 0);
    chk({t, "_flip"}, int'(FlipBuffer), 0);
    chk({t, "_blockdone"}, int'(BlockDone), 0);
    chk({t, "_framedone"}, int'(FrameDone), 0);
  endtask

  initial begin
    int r0, w0, nff, n;
    for (int c = 0; c < 16; c++) begin
      mat[3*c] = 8'h40; mat[3*c+1] = 8'h80; mat[3*c+2] = 8'hC0;
    end
    repeat (3) @(posedge sys_clock);
    @(negedge sys_clock);
    check_zero("reset");
    sys_reset = 1'b0;
    @(negedge sys_clock);
    check_zero("post_reset");

    // four thresholds boundary samples at (0..3,0)
    send_pixel(8'hC0); send_pixel(8'h80);
    send_pixel(8'h40); send_pixel(8'h3F);
    drain();
    chk("t1_reads", rd_n, 12);
    chk("t1_writes", wr_n, 1);
    chk("t1_first_rd", rd_log[0], 32'h200);
    chk("t1_last_rd", rd_log[11], 32'h20B);
    chk("t1_off", wo_log[0], 0);
    chk("t1_data", wd_log[0], 32'h1B);

    // rest of a dark frame
    for (int i = 4; i < 128 * ROWS; i++) send_pixel(8'h00);
    drain();
    chk("frame_writes", wr_n, 32 * ROWS);
    chk("px56_rd_l", rd_log[3*773], 32'h21B);
    chk("px56_rd_m", rd_log[3*773+1], 32'h21C);
    chk("px56_rd_h", rd_log[3*773+2], 32'h21D);
    chk("blk7_off", wo_log[255], 32'h0FF);
    nff = 0;
    for (int i = 1; i < 32 * ROWS; i++) if (wd_log[i] == 255) nff++;
    chk("frame_ff_count", nff, 32 * ROWS - 1);
    chk("frame_blocks", blk_n, ROWS / 8);
    chk("frame_done_cnt", fd_n, 1);

    // post-frame samples restart at (0,0)
    r0 = rd_n; w0 = wr_n;
    for (int i = 0; i < 4; i++) send_pixel(8'hC0);
    drain();
    chk("newfrm_rd", rd_log[r0], 32'h200);
    chk("newfrm_off", wo_log[w0], 0);
    chk("newfrm_data", wd_log[w0], 0);

    // random responder latency with a varied matrix
    for (int c = 0; c < 16; c++) begin
      mat[3*c]   = 8'(32'h20 + 4 * c);
      mat[3*c+1] = 8'(32'h70 + 4 * c);
      mat[3*c+2] = 8'(32'hB0 + 4 * c);
    end
    mat[15] = 8'hC0; mat[16] = 8'h40; mat[17] = 8'h80;
    dmin = 0; dmax = 5;
    for (int i = 0; i < 400; i++) send_pixel(8'($urandom_range(0, 255)));
    drain();
    dmax = 0;

    // Frame_Start together with Pix_Valid wins
    @(posedge sys_clock); #1;
    Frame_Start = 1'b1; Pix_Valid = 1'b1; Pix_Data = 8'h55;
    model_reset();
    @(posedge sys_clock); #1;
    Frame_Start = 1'b0;
    @(negedge sys_clock);
    chk("fs_no_accept", int'(Pix_Ready), 0);
    model_pix(8'h55);
    wait_ready();
    send_pixel(8'h66);
    dmin = 4; dmax = 4;
    @(posedge sys_clock); #1;
    Pix_Valid = 1'b1; Pix_Data = 8'h77;
    model_pix(8'h77);
    wait_ready();
    n = 0;
    do begin
      @(negedge sys_clock);
      n++;
    end while (!(RequestReadReg && RegReadAddr == 10'h207) && n < 50);
    if (n >= 50) fail("rd_m_timeout");
    @(posedge sys_clock); #1;
    Frame_Start = 1'b1;
    model_reset();
    @(posedge sys_clock); #1;
    Frame_Start = 1'b0;
    @(negedge sys_clock);
    chk("fs_req_drop", int'(RequestReadReg), 0);
    dmin = 0; dmax = 0;
    w0 = wr_n;
    send_pixel(8'h00); send_pixel(8'hFF);
    send_pixel(8'h00); send_pixel(8'hFF);
    drain();
    chk("fs_off", wo_log[w0], 0);
    chk("fs_data", wd_log[w0], 32'hCC);

    // asynchronous reset in the middle of WR
    dmin = 5; dmax = 5;
    for (int i = 0; i < 4; i++) send_pixel(8'h00);
    n = 0;
    do begin
      @(negedge sys_clock);
      n++;
    end while (!RequestWriteBuffer && n < 50);
    if (n >= 50) fail("wr_req_timeout");
    #1 sys_reset = 1'b1;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge sys_clock);
    sys_reset = 1'b0;
    dmin = 0; dmax = 0;
    w0 = wr_n;
    for (int i = 0; i < 4; i++) send_pixel(8'hFF);
    drain();
    chk("rst_off", wo_log[w0], 0);
    chk("rst_data", wd_log[w0], 0);
    chk("rst_writes", wr_n - w0, 1);

    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("flip_queue_empty", exp_fl.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
